// File: rtl/command_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_pkg
//  Description : Shared constants and types for the command receiver.
//                Holds the UART opcode values, the result-command encoding
//                understood by vector_processing, the receiver state type and
//                the BRAM address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_pkg;

    // BRAM write-port address width
    localparam int BRAM_ADDR_W = 10;

    // One-byte opcodes received over UART
    localparam logic [7:0] OP_LOAD_A   = 8'h01;
    localparam logic [7:0] OP_LOAD_B   = 8'h02;
    localparam logic [7:0] OP_READ_A   = 8'h03;
    localparam logic [7:0] OP_READ_B   = 8'h04;
    localparam logic [7:0] OP_SUM      = 8'h05;
    localparam logic [7:0] OP_AVG      = 8'h06;
    localparam logic [7:0] OP_EUC_DIST = 8'h07;
    localparam logic [7:0] OP_MAN_DIST = 8'h08;

    // Result commands: [3]=valid, [2]=vector(1)/scalar(0), [1:0]=op
    localparam logic [3:0] RES_NONE     = 4'b0000;
    localparam logic [3:0] RES_READ_A   = 4'b1100;
    localparam logic [3:0] RES_READ_B   = 4'b1101;
    localparam logic [3:0] RES_SUM      = 4'b1110;
    localparam logic [3:0] RES_AVG      = 4'b1111;
    localparam logic [3:0] RES_EUC_DIST = 4'b1000;
    localparam logic [3:0] RES_MAN_DIST = 4'b1001;

    // Encoding chosen so that bit 0 is "busy" (any non-IDLE state) and
    // bit 1 is "load_active"; both outputs come straight off state flops.
    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        ISSUE     = 3'b001,
        LOAD      = 3'b011,
        WAIT_DONE = 3'b101
    } rx_state_t;

    // Maps a processing opcode to its result command; RES_NONE for anything
    // that is not a processing opcode (load opcodes included).
    function automatic logic [3:0] op_to_result(input logic [7:0] op);
        logic [3:0] res;
        res = RES_NONE;
        case (op)
            OP_READ_A:   res = RES_READ_A;
            OP_READ_B:   res = RES_READ_B;
            OP_SUM:      res = RES_SUM;
            OP_AVG:      res = RES_AVG;
            OP_EUC_DIST: res = RES_EUC_DIST;
            OP_MAN_DIST: res = RES_MAN_DIST;
            default:     res = RES_NONE;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/command_receiver_rx_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : rx_timeout
//  Description : Inter-byte timeout counter. Counts enabled cycles since the
//                last clear and flags expiry in the cycle the count sits at
//                TIMEOUT-1 with no clear pending.
//  Ports       : clk, reset (async, active-low)
//                i_clear  - synchronous clear (wins over enable)
//                i_enable - count enable
//                o_expire - high while expired and not being cleared
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_timeout #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  C_LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Saturates at the limit so an unattended counter never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != C_LIMIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // A clear in the expiry cycle (byte arrived) suppresses the expiry.
    assign o_expire = i_enable & ~i_clear & (r_count == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/command_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : command_receiver
//  Description : Decodes UART opcodes. Load opcodes stream NBytes payload
//                bytes into BRAM_A or BRAM_B; processing opcodes issue a
//                one-cycle result command and wait for proc_done.
//  Ports       : clk, reset (async, active-low)
//                rx_data/rx_ready     - received UART byte and its strobe
//                proc_done            - vector_processing completion pulse
//                bram_we_a/_b, bram_waddr, bram_wdata - BRAM write port
//                load_active          - BRAM address mux select (LOAD state)
//                result               - {valid, vector/scalar, op[1:0]}
//                busy                 - not IDLE
//                load_done, error     - one-cycle status pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module command_receiver
    import acc_pkg::*;
#(
    parameter int NBytes  = 1024,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    input  logic                   proc_done,
    output logic                   bram_we_a,
    output logic                   bram_we_b,
    output logic [BRAM_ADDR_W-1:0] bram_waddr,
    output logic [7:0]             bram_wdata,
    output logic                   load_active,
    output logic [3:0]             result,
    output logic                   busy,
    output logic                   load_done,
    output logic                   error
);

    localparam logic [BRAM_ADDR_W-1:0] C_LAST_ADDR = BRAM_ADDR_W'(NBytes - 1);

    rx_state_t              r_state;
    logic                   r_sel_b;     // load target: 0=A, 1=B
    logic [3:0]             r_res;       // latched result command
    logic [BRAM_ADDR_W-1:0] r_addr;      // next payload address
    logic                   r_last_wr;   // final write strobe is on the port
    logic                   r_we_a;
    logic                   r_we_b;
    logic [BRAM_ADDR_W-1:0] r_waddr;
    logic [7:0]             r_wdata;
    logic [3:0]             r_result;
    logic                   r_load_done;
    logic                   r_error;

    logic w_tmo_clear;
    logic w_tmo_en;
    logic w_expire;

    // Held clear outside LOAD so each load starts from zero; a byte in LOAD
    // restarts the inter-byte window.
    assign w_tmo_clear = (r_state != LOAD) | rx_ready;
    assign w_tmo_en    = (r_state == LOAD);

    rx_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_rx_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_sel_b     <= 1'b0;
            r_res       <= RES_NONE;
            r_addr      <= '0;
            r_last_wr   <= 1'b0;
            r_we_a      <= 1'b0;
            r_we_b      <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_result    <= RES_NONE;
            r_load_done <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle
            r_we_a      <= 1'b0;
            r_we_b      <= 1'b0;
            r_result    <= RES_NONE;
            r_load_done <= 1'b0;
            r_error     <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (rx_ready) begin
                        if ((rx_data == OP_LOAD_A) || (rx_data == OP_LOAD_B)) begin
                            r_sel_b   <= (rx_data == OP_LOAD_B);
                            r_addr    <= '0;
                            r_last_wr <= 1'b0;
                            r_state   <= LOAD;
                        end else if (op_to_result(rx_data) != RES_NONE) begin
                            r_res   <= op_to_result(rx_data);
                            r_state <= ISSUE;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (r_last_wr) begin
                        // Stay in LOAD through the final strobe so the address
                        // mux still selects the write port, then report.
                        r_last_wr   <= 1'b0;
                        r_load_done <= 1'b1;
                        r_state     <= IDLE;
                    end else if (rx_ready) begin
                        // A byte takes priority over a same-cycle expiry.
                        r_we_a    <= ~r_sel_b;
                        r_we_b    <= r_sel_b;
                        r_waddr   <= r_addr;
                        r_wdata   <= rx_data;
                        r_last_wr <= (r_addr == C_LAST_ADDR);
                        r_addr    <= (r_addr == C_LAST_ADDR) ? '0
                                                             : r_addr + BRAM_ADDR_W'(1);
                    end else if (w_expire) begin
                        r_error <= 1'b1;
                        r_state <= IDLE;
                    end
                end

                ISSUE: begin
                    r_result <= r_res;
                    r_state  <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    // Incoming bytes are silently dropped here.
                    if (proc_done) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bram_we_a   = r_we_a;
    assign bram_we_b   = r_we_b;
    assign bram_waddr  = r_waddr;
    assign bram_wdata  = r_wdata;
    assign result      = r_result;
    assign load_done   = r_load_done;
    assign error       = r_error;
    assign busy        = r_state[0];
    assign load_active = r_state[1];

endmodule
`default_nettype wire

// File: tb/tb_command_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_command_receiver
//  Description : Self-checking bench for command_receiver (NBytes=1024,
//                TIMEOUT=50). Opcode decode is table driven; loads, timeout,
//                coincident events and asynchronous reset are hand sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_command_receiver;

    localparam int TMO = 50;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       proc_done;
    logic       bram_we_a;
    logic       bram_we_b;
    logic [9:0] bram_waddr;
    logic [7:0] bram_wdata;
    logic       load_active;
    logic [3:0] result;
    logic       busy;
    logic       load_done;
    logic       error;

    command_receiver #(
        .NBytes  (1024),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .proc_done   (proc_done),
        .bram_we_a   (bram_we_a),
        .bram_we_b   (bram_we_b),
        .bram_waddr  (bram_waddr),
        .bram_wdata  (bram_wdata),
        .load_active (load_active),
        .result      (result),
        .busy        (busy),
        .load_done   (load_done),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cnt_a  = 0;
    int cnt_b  = 0;
    int cnt_ld = 0;

    always @(negedge clk) begin
        if (bram_we_a) cnt_a++;
        if (bram_we_b) cnt_b++;
        if (load_done) cnt_ld++;
    end

    typedef struct {
        logic [7:0] op;
        logic       is_proc;
        logic       exp_err;
        logic [3:0] exp_res;
    } op_vec_t;

    op_vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rx_ready high for one cycle; returns in the following cycle.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    function automatic logic [27:0] all_outs();
        return {bram_we_a, bram_we_b, bram_waddr, bram_wdata, load_active,
                result, busy, load_done, error};
    endfunction

    initial begin
        int         base_a, base_b, base_ld, lat;
        logic       found;
        logic [9:0] av;

        vecs[0]  = '{8'h03, 1'b1, 1'b0, 4'b1100};
        vecs[1]  = '{8'h04, 1'b1, 1'b0, 4'b1101};
        vecs[2]  = '{8'h05, 1'b1, 1'b0, 4'b1110};
        vecs[3]  = '{8'h06, 1'b1, 1'b0, 4'b1111};
        vecs[4]  = '{8'h07, 1'b1, 1'b0, 4'b1000};
        vecs[5]  = '{8'h08, 1'b1, 1'b0, 4'b1001};
        vecs[6]  = '{8'h2A, 1'b0, 1'b1, 4'b0000};
        vecs[7]  = '{8'h00, 1'b0, 1'b1, 4'b0000};
        vecs[8]  = '{8'h09, 1'b0, 1'b1, 4'b0000};
        vecs[9]  = '{8'hFF, 1'b0, 1'b1, 4'b0000};
        vecs[10] = '{8'h81, 1'b0, 1'b1, 4'b0000};
        vecs[11] = '{8'h05, 1'b1, 1'b0, 4'b1110};

        reset     = 1'b0;
        rx_data   = 8'h00;
        rx_ready  = 1'b0;
        proc_done = 1'b0;
        repeat (3) tick();
        chk("reset state", 64'(all_outs()), 64'd0);
        reset = 1'b1;
        tick();

        // ---------------- opcode decode table ----------------
        for (int i = 0; i < 12; i++) begin
            base_a = cnt_a;
            base_b = cnt_b;
            send_byte(vecs[i].op);
            chk($sformatf("op %02h err/busy", vecs[i].op),
                {error, busy, result}, {vecs[i].exp_err, vecs[i].is_proc, 4'b0000});
            tick();
            chk($sformatf("op %02h result", vecs[i].op),
                {result, error}, {vecs[i].exp_res, 1'b0});
            if (vecs[i].is_proc) begin
                tick();
                chk("result one cycle", {result, busy}, {4'b0000, 1'b1});
                send_byte(8'h01);   // dropped while waiting
                tick();
                chk("wait_done hold", {busy, load_active, result, error},
                    {1'b1, 1'b0, 4'b0000, 1'b0});
                proc_done = 1'b1;
                tick();
                proc_done = 1'b0;
                chk("done -> idle", busy, 1'b0);
            end else begin
                chk("bad op stays idle", busy, 1'b0);
            end
            chk("no writes in decode", 64'(cnt_a - base_a + cnt_b - base_b), 64'd0);
        end

        // ---------------- byte coincident with proc_done is dropped ----------------
        send_byte(8'h06);
        tick();
        tick();
        rx_data   = 8'h01;
        rx_ready  = 1'b1;
        proc_done = 1'b1;
        tick();
        rx_ready  = 1'b0;
        proc_done = 1'b0;
        chk("done+byte idle", busy, 1'b0);
        tick();
        chk("done+byte dropped", {busy, load_active, error}, 3'b000);

        // ---------------- full load of BRAM_A ----------------
        base_a  = cnt_a;
        base_b  = cnt_b;
        base_ld = cnt_ld;
        send_byte(8'h01);
        chk("loadA entry", {load_active, busy}, 2'b11);
        for (int a = 0; a < 1024; a++) begin
            av = a[9:0];
            send_byte(av[7:0]);
            chk($sformatf("loadA wr %0d", a),
                {bram_we_a, bram_we_b, bram_waddr, bram_wdata, load_done},
                {1'b1, 1'b0, av, av[7:0], 1'b0});
        end
        tick();
        chk("loadA done pulse", {load_done, load_active, busy}, 3'b100);
        tick();
        chk("loadA done once", {load_done, bram_we_a}, 2'b00);
        chk("loadA write count", 64'(cnt_a - base_a), 64'd1024);
        chk("loadA no B writes", 64'(cnt_b - base_b), 64'd0);
        chk("loadA done count", 64'(cnt_ld - base_ld), 64'd1);

        // ---------------- load B, 10 bytes, then timeout ----------------
        base_b = cnt_b;
        send_byte(8'h02);
        for (int i = 0; i < 10; i++) begin
            av = i[9:0];
            send_byte(8'hA0 + av[7:0]);
            chk($sformatf("loadB wr %0d", i),
                {bram_we_a, bram_we_b, bram_waddr, bram_wdata},
                {1'b0, 1'b1, av, 8'hA0 + av[7:0]});
        end
        // Now in the last strobe cycle (index 1); error is due TMO cycles later.
        found = 1'b0;
        lat   = 0;
        for (int c = 2; c <= 200 && !found; c++) begin
            tick();
            if (error) begin
                found = 1'b1;
                lat   = c;
            end
        end
        chk("timeout latency", 64'(lat), 64'(TMO + 1));
        chk("timeout -> idle", {load_active, busy, error}, 3'b001);
        tick();
        chk("timeout error one cycle", error, 1'b0);
        chk("loadB write count", 64'(cnt_b - base_b), 64'd10);
        send_byte(8'h03);
        tick();
        chk("read_a after timeout", result, 4'b1100);
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;

        // ---------------- byte coincident with expiry ----------------
        send_byte(8'h01);
        send_byte(8'h55);
        chk("coinc first wr", {bram_we_a, bram_waddr, bram_wdata}, {1'b1, 10'd0, 8'h55});
        repeat (TMO - 1) tick();
        send_byte(8'h66);
        chk("coinc byte wins", {bram_we_a, bram_waddr, bram_wdata, error, load_active},
            {1'b1, 10'd1, 8'h66, 1'b0, 1'b1});
        tick();
        chk("coinc no error", {error, load_active}, 2'b01);

        // ---------------- reset mid-load at address 500 ----------------
        for (int a = 2; a <= 500; a++) begin
            av = a[9:0];
            send_byte(av[7:0] ^ 8'h5A);
        end
        chk("pre-reset wr 500", {bram_we_a, bram_waddr, bram_wdata, load_active},
            {1'b1, 10'd500, 8'hF4 ^ 8'h5A, 1'b1});
        #2 reset = 1'b0;
        #1;
        chk("async reset outputs", 64'(all_outs()), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        send_byte(8'h01);
        send_byte(8'h77);
        chk("reload from addr 0", {bram_we_a, bram_we_b, bram_waddr, bram_wdata},
            {1'b1, 1'b0, 10'd0, 8'h77});
        repeat (TMO + 5) tick();
        chk("reload timed out idle", {busy, load_active}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
